// File: rtl/slc3_pkg.sv
// Shared SLC-3 control definitions: sequencer states, opcodes and datapath select encodings.
package slc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKE, S_JMP,
    S_JSR1, S_JSR2, S_LDR1, S_LDR2, S_LDR3,
    S_STR1, S_STR2, S_STR3, S_PAUSE1, S_PAUSE2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] ALUK_ADD  = 2'd0;
  localparam logic [1:0] ALUK_AND  = 2'd1;
  localparam logic [1:0] ALUK_NOT  = 2'd2;
  localparam logic [1:0] ALUK_PASS = 2'd3;

  localparam logic [1:0] PCMUX_INC   = 2'd0;
  localparam logic [1:0] PCMUX_BUS   = 2'd1;
  localparam logic [1:0] PCMUX_ADDER = 2'd2;

  localparam logic [1:0] ADDR2_ZERO  = 2'd0;
  localparam logic [1:0] ADDR2_OFF6  = 2'd1;
  localparam logic [1:0] ADDR2_OFF9  = 2'd2;
  localparam logic [1:0] ADDR2_OFF11 = 2'd3;

  // States that hold a memory strobe for MEM_WAIT cycles.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
  endfunction

endpackage

// File: rtl/slc3_mem_wait_ctr.sv
// Memory wait-state counter: cleared by start, done once MEM_WAIT-1 is reached.
module slc3_mem_wait_ctr #(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic start,
  output logic done
);

  localparam int unsigned CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)           count <= '0;
    else if (start)         count <= '0;
    else if (count != LAST) count <= count + CW'(1);
  end

  assign done = (count == LAST);

endmodule

// File: rtl/slc3_control_fsm.sv
// SLC-3 fetch/decode/execute sequencer driving datapath load enables, gates, selects and memory strobes.
module slc3_control_fsm
  import slc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  state_t state, state_next;
  logic   wait_start, wait_done;

  // Counter restarts only on a fresh entry into a wait state.
  assign wait_start = is_wait_state(state_next) && (state_next != state);

  slc3_mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait_ctr (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .start  (wait_start),
    .done   (wait_done)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_HALTED;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_HALTED:  if (Run) state_next = S_FETCH1;
      S_FETCH1:  state_next = S_FETCH2;
      S_FETCH2:  if (wait_done) state_next = S_FETCH3;
      S_FETCH3:  state_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_ADD:   state_next = S_ADD;
          OP_AND:   state_next = S_AND;
          OP_NOT:   state_next = S_NOT;
          OP_BR:    state_next = S_BR;
          OP_JMP:   state_next = S_JMP;
          OP_JSR:   state_next = S_JSR1;
          OP_LDR:   state_next = S_LDR1;
          OP_STR:   state_next = S_STR1;
          OP_PAUSE: state_next = S_PAUSE1;
          default:  state_next = S_FETCH1;
        endcase
      end
      S_BR:      state_next = BEN ? S_BR_TAKE : S_FETCH1;
      S_JSR1:    state_next = S_JSR2;
      S_LDR1:    state_next = S_LDR2;
      S_LDR2:    if (wait_done) state_next = S_LDR3;
      S_STR1:    state_next = S_STR2;
      S_STR2:    state_next = S_STR3;
      S_STR3:    if (wait_done) state_next = S_FETCH1;
      S_PAUSE1:  if (Continue) state_next = S_PAUSE2;
      S_PAUSE2:  if (!Continue) state_next = S_FETCH1;
      default:   state_next = S_FETCH1;
    endcase
  end

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = PCMUX_INC; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_ZERO; ALUK = ALUK_ADD;
    Mem_OE = 1'b0; Mem_WE = 1'b0;
    unique case (state)
      S_FETCH1: begin GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = PCMUX_INC; LD_PC = 1'b1; end
      S_FETCH2, S_LDR2: begin Mem_OE = 1'b1; LD_MDR = wait_done; end
      S_FETCH3: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S_DECODE: LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR2MUX = IR_5;
        ALUK = (state == S_ADD) ? ALUK_ADD : (state == S_AND) ? ALUK_AND : ALUK_NOT;
      end
      S_BR_TAKE: begin ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_OFF9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; end
      S_JMP:  begin ALUK = ALUK_PASS; PCMUX = PCMUX_BUS; GateALU = 1'b1; LD_PC = 1'b1; end
      S_JSR1: begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S_JSR2: begin
        LD_PC = 1'b1;
        if (IR_11) begin ADDR2MUX = ADDR2_OFF11; PCMUX = PCMUX_ADDER; end
        else       begin ALUK = ALUK_PASS; GateALU = 1'b1; PCMUX = PCMUX_BUS; end
      end
      S_LDR1, S_STR1: begin ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF6; GateMARMUX = 1'b1; LD_MAR = 1'b1; end
      S_LDR3: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S_STR2: begin SR1MUX = 1'b0; ALUK = ALUK_PASS; GateALU = 1'b1; LD_MDR = 1'b1; end
      S_STR3: Mem_WE = 1'b1;
      S_PAUSE1: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_slc3_control_fsm.sv
// Randomized instruction-stream bench for slc3_control_fsm against a per-instruction micro-step schedule model.
module tb_slc3_control_fsm;

  localparam int unsigned M = 3;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic mem_oe, mem_we;
  } ctl_t;

  typedef struct {
    logic cont;
    ctl_t c;
  } step_t;

  logic Clk = 1'b0, Reset_n, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;

  int unsigned n_checks = 0, n_pass = 0;
  step_t exp_q[$];

  slc3_control_fsm #(.MEM_WAIT(M)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic ctl_t observed();
    ctl_t o;
    o = '{ld_mar: LD_MAR, ld_mdr: LD_MDR, ld_ir: LD_IR, ld_ben: LD_BEN, ld_cc: LD_CC,
           ld_reg: LD_REG, ld_pc: LD_PC, ld_led: LD_LED, gate_pc: GatePC, gate_mdr: GateMDR,
           gate_alu: GateALU, gate_marmux: GateMARMUX, pcmux: PCMUX, drmux: DRMUX,
           sr1mux: SR1MUX, sr2mux: SR2MUX, addr1mux: ADDR1MUX, addr2mux: ADDR2MUX,
           aluk: ALUK, mem_oe: Mem_OE, mem_we: Mem_WE};
    return o;
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, want);
  endtask

  task automatic push(input ctl_t c, input logic cont);
    step_t s;
    s.cont = cont;
    s.c    = c;
    exp_q.push_back(s);
  endtask

  // Expected control word, one entry per clock, for a whole instruction from FETCH1 onward.
  task automatic build_instr(input logic [3:0] op, input logic ir5, input logic ir11,
                             input logic ben, input int unsigned hold0, input int unsigned hold1);
    ctl_t c;
    c = '0; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; push(c, 0);
    for (int unsigned i = 0; i < M; i++) begin
      c = '0; c.mem_oe = 1; c.ld_mdr = (i == M - 1); push(c, 0);
    end
    c = '0; c.gate_mdr = 1; c.ld_ir = 1; push(c, 0);
    c = '0; c.ld_ben = 1; push(c, 0);
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        c = '0; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr2mux = ir5;
        c.aluk = (op == 4'b0001) ? 2'd0 : (op == 4'b0101) ? 2'd1 : 2'd2;
        push(c, 0);
      end
      4'b0000: begin
        push('0, 0);
        if (ben) begin c = '0; c.addr2mux = 2; c.pcmux = 2; c.ld_pc = 1; push(c, 0); end
      end
      4'b1100: begin c = '0; c.aluk = 3; c.pcmux = 1; c.gate_alu = 1; c.ld_pc = 1; push(c, 0); end
      4'b0100: begin
        c = '0; c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; push(c, 0);
        c = '0; c.ld_pc = 1;
        if (ir11) begin c.addr2mux = 3; c.pcmux = 2; end
        else begin c.aluk = 3; c.gate_alu = 1; c.pcmux = 1; end
        push(c, 0);
      end
      4'b0110, 4'b0111: begin
        c = '0; c.addr1mux = 1; c.addr2mux = 1; c.gate_marmux = 1; c.ld_mar = 1; push(c, 0);
        if (op == 4'b0110) begin
          for (int unsigned i = 0; i < M; i++) begin
            c = '0; c.mem_oe = 1; c.ld_mdr = (i == M - 1); push(c, 0);
          end
          c = '0; c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; push(c, 0);
        end else begin
          c = '0; c.aluk = 3; c.gate_alu = 1; c.ld_mdr = 1; push(c, 0);
          for (int unsigned i = 0; i < M; i++) begin
            c = '0; c.mem_we = 1; push(c, 0);
          end
        end
      end
      4'b1101: begin
        c = '0; c.ld_led = 1;
        for (int unsigned i = 0; i < hold0; i++) push(c, 0);
        push(c, 1);
        for (int unsigned i = 0; i < hold1; i++) push('0, 1);
        push('0, 0);
      end
      default: ;
    endcase
  endtask

  int op_tab[12]   = '{1, 5, 9, 0, 0, 12, 4, 4, 6, 7, 13, 15};
  int flag_tab[12] = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    ctl_t c;
    step_t s;
    int unsigned idx;
    logic [3:0] op;
    logic f;

    Reset_n = 0; Run = 0; Continue = 0; Opcode = '0; IR_5 = 0; IR_11 = 0; BEN = 0;
    #12;
    check("reset_outputs", observed(), '0);
    Reset_n = 1;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("halted_idle", observed(), '0);
    Run = 1;
    @(posedge Clk); #1;

    for (int i = 0; i < 60; i++) begin
      if (i < 12) begin
        op = 4'(op_tab[i]); f = flag_tab[i][0];
        IR_5 = f; IR_11 = f; BEN = f;
      end else begin
        op = 4'($urandom_range(0, 15));
        IR_5 = 1'($urandom); IR_11 = 1'($urandom); BEN = 1'($urandom);
      end
      Opcode = op;
      build_instr(op, IR_5, IR_11, BEN, $urandom_range(0, 3), $urandom_range(0, 3));
      idx = 0;
      while (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        Continue = s.cont;
        Run = (i < 12) ? 1'b1 : 1'($urandom);
        @(negedge Clk);
        check($sformatf("instr%0d_op%b_step%0d", i, op, idx), observed(), s.c);
        idx++;
        @(posedge Clk); #1;
      end
    end

    Opcode = 4'b1111;
    @(negedge Clk);
    c = '0; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1;
    check("pre_reset_fetch1", observed(), c);
    @(posedge Clk); #1;
    @(negedge Clk);
    c = '0; c.mem_oe = 1;
    check("pre_reset_fetch2", observed(), c);
    #2 Reset_n = 0; Run = 0;
    #1 check("async_reset_mid_fetch2", observed(), '0);
    @(posedge Clk); #1;
    check("held_reset", observed(), '0);
    Reset_n = 1;
    @(posedge Clk); #1;
    check("halted_after_reset", observed(), '0);
    Run = 1;
    @(posedge Clk); #1;
    c = '0; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1;
    check("restart_fetch1", observed(), c);
    @(posedge Clk); #1;
    c = '0; c.mem_oe = 1;
    check("restart_fetch2", observed(), c);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
